// File: rtl/simon_tick_gen.sv
// Multi-channel programmable tick generator: each channel emits a one-cycle tick
// every div+1 enabled cycles and a square wave that toggles on every tick.
module simon_tick_gen #(
    parameter int          WIDTH       = 27,
    parameter int          NCH         = 4,
    parameter int unsigned DEFAULT_DIV = 50_000_000 - 1,
    parameter int          CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_oneshot,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   slow_clk,
    output logic [NCH-1:0]   active
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("simon_tick_gen: NCH must be in 1..16");
    end
    if (WIDTH < 32 && (DEFAULT_DIV >> WIDTH) != 0) begin : g_bad_div
        $error("simon_tick_gen: DEFAULT_DIV does not fit in WIDTH");
    end

    logic [WIDTH-1:0] cnt [NCH];
    logic [WIDTH-1:0] div [NCH];
    logic [NCH-1:0]   oneshot;
    logic [NCH-1:0]   armed;
    logic [NCH-1:0]   wr_hit;

    // Out-of-range channel indices simply match no channel.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
                div[i] <= DIV_RST;
            end
            oneshot  <= '0;
            armed    <= '1;
            tick     <= '0;
            slow_clk <= '0;
        end else begin
            tick <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (sync) begin
                    cnt[i]      <= '0;
                    slow_clk[i] <= 1'b0;
                    armed[i]    <= 1'b1;
                    if (wr_hit[i]) begin
                        div[i]     <= wr_div;
                        oneshot[i] <= wr_oneshot;
                    end
                end else if (wr_hit[i]) begin
                    div[i]     <= wr_div;
                    oneshot[i] <= wr_oneshot;
                    cnt[i]     <= '0;
                    armed[i]   <= 1'b1;
                end else if (enable && armed[i]) begin
                    // Compare before increment so an all-ones divisor never wraps.
                    if (cnt[i] == div[i]) begin
                        cnt[i]      <= '0;
                        tick[i]     <= 1'b1;
                        slow_clk[i] <= ~slow_clk[i];
                        if (oneshot[i]) begin
                            armed[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

    assign active = armed;

endmodule
